// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO addresses, STATUS bit layout
// and the address-decode selector type.
package dmem_pkg;

  localparam logic [31:0] ADDR_STATUS  = 32'h0001_0000;
  localparam logic [31:0] ADDR_TX_DATA = 32'h0001_0004;
  localparam logic [31:0] ADDR_CYCLES  = 32'h0001_0008;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_RAM    = 3'd1,
    SEL_STATUS = 3'd2,
    SEL_TX     = 3'd3,
    SEL_CYCLES = 3'd4
  } sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_q];
  assign count = count_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    if (do_pop_s) begin
      rd_d = rd_q + 1'b1;
    end else begin
      rd_d = rd_q;
    end
    if (do_push_s) begin
      wr_d = wr_q + 1'b1;
    end else begin
      wr_d = wr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data port responder: word RAM plus MMIO (STATUS, TX_DATA stream FIFO, CYCLES).
// Define DMEM_CYCLE_CNT_EN to build the free-running CYCLES counter; otherwise CYCLES reads 0.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int OUT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_we,
  input  logic [31:0]      mem_address,
  input  logic [31:0]      mem_wdata,
  output logic [31:0]      mem_rdata,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready
);

  localparam int RAW = $clog2(RAM_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    ram_q [RAM_DEPTH];
  logic [RAW-1:0] ram_idx_s;
  sel_e           sel_s;
  logic           ram_we_s, status_we_s, tx_we_s, pop_s;
  logic           full_s, empty_s;
  logic [CW-1:0]  count_s;
  logic [31:0]    status_s, cyc_rd_s;
  logic           ovf_q, ovf_d;
  logic           unused_s;

  assign unused_s  = ^mem_address[1:0];
  assign ram_idx_s = mem_address[RAW+1:2];

  // Address decode on the word address.
  always_comb begin
    if (mem_address[31:RAW+2] == '0) begin
      sel_s = SEL_RAM;
    end else begin
      case (mem_address[31:2])
        ADDR_STATUS[31:2]:  sel_s = SEL_STATUS;
        ADDR_TX_DATA[31:2]: sel_s = SEL_TX;
        ADDR_CYCLES[31:2]:  sel_s = SEL_CYCLES;
        default:            sel_s = SEL_NONE;
      endcase
    end
  end

  assign ram_we_s    = mem_we && !rst && (sel_s == SEL_RAM);
  assign status_we_s = mem_we && (sel_s == SEL_STATUS);
  assign tx_we_s     = mem_we && !rst && (sel_s == SEL_TX);
  assign pop_s       = !empty_s && out_ready;
  assign out_valid   = !empty_s;

  // Asynchronous-read RAM, written on the rising edge.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= mem_wdata;
    end
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_we_s),
    .push_data (mem_wdata[OUT_W-1:0]),
    .pop       (pop_s),
    .head      (out_data),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Sticky overflow: a push refused because the FIFO is full and nothing drains.
  always_comb begin
    ovf_d = ovf_q;
    if (status_we_s) begin
      ovf_d = 1'b0;
    end else if (tx_we_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Write-clear wins over the increment.
  always_comb begin
    if (mem_we && (sel_s == SEL_CYCLES)) begin
      cyc_d = 32'h0000_0000;
    end else begin
      cyc_d = cyc_q + 32'h0000_0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 32'h0000_0000;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_rd_s = cyc_q;
`else
  assign cyc_rd_s = 32'h0000_0000;
`endif

  always_comb begin
    status_s                         = 32'h0000_0000;
    status_s[ST_EMPTY]               = empty_s;
    status_s[ST_FULL]                = full_s;
    status_s[ST_OVF]                 = ovf_q;
    status_s[ST_COUNT_LSB +: CW]     = count_s;
  end

  // Zero-latency read mux.
  always_comb begin
    case (sel_s)
      SEL_RAM:    mem_rdata = ram_q[ram_idx_s];
      SEL_STATUS: mem_rdata = status_s;
      SEL_CYCLES: mem_rdata = cyc_rd_s;
      default:    mem_rdata = 32'h0000_0000;
    endcase
  end

endmodule
